int_wb_arbiter: RTL
===================

Name: int_wb_arbiter

Overview:
Shares the single write port of the integer register file between N_SRC writeback requesters: ALU (0), load unit (1) and multiplier (2). Uses round-robin arbitration with a valid/ready handshake per source. The winning write is registered and presented to the register file write port one cycle after acceptance. Writes to x0 are accepted and discarded here, so the register file never sees them.

Parameters:
N_SRC, 3, number of writeback requesters (2..8)
DATA_W, 32, write data width
ADDR_W, 5, register address width

Ports:
clk_i  input  1  clock, rising edge
rsn_i  input  1  reset; asynchronous, active-low
flush_i  input  1  synchronous; blocks all grants in the current cycle
req_valid_i  input  N_SRC  per-source write request
req_addr_i  input  N_SRC*ADDR_W  per-source destination register; source i at [i*ADDR_W +: ADDR_W]
req_data_i  input  N_SRC*DATA_W  per-source write data; source i at [i*DATA_W +: DATA_W]
req_ready_o  input-side handshake, output  N_SRC  one-hot grant; combinational
write_enable_o  output  1  register file write enable
write_addr_o  output  ADDR_W  register file write address
write_data_o  output  DATA_W  register file write data
wb_src_o  output  3  index of the source that produced the current write
busy_o  output  1  high when any req_valid_i is high and that source has no grant this cycle

Behaviour:
- Reset (rsn_i low, asynchronous):
  - write_enable_o=0, write_addr_o=0, write_data_o=0, wb_src_o=0.
  - Priority pointer ptr=0.
  - req_ready_o is 0 while reset is asserted.
- Handshake:
  - Source i transfers in a cycle when req_valid_i[i] && req_ready_o[i].
  - A source holds valid, addr and data stable until it transfers.
  - A source may drop valid before transfer only on flush.
- Grant (combinational):
  - With flush_i=0, req_ready_o grants exactly one valid source: the first valid index found scanning ptr, ptr+1, ..., wrapping modulo N_SRC.
  - No valid source gives req_ready_o=0.
  - flush_i=1 gives req_ready_o=0.
  - req_ready_o depends only on req_valid_i, ptr and flush_i, never on addr or data.
- Pointer update:
  - On a transfer from source g, ptr becomes (g+1) mod N_SRC at the next clock edge.
  - With no transfer, ptr holds.
  - Wrap: g=N_SRC-1 sets ptr to 0.
- Output stage (1-cycle latency):
  - On a transfer from source g, the next edge sets write_addr_o, write_data_o and wb_src_o from source g.
  - In the same case, write_enable_o = (addr != 0).
  - With no transfer, write_enable_o=0; addr, data and src hold their last values.
  - The register file commits at the edge after that, so total latency from acceptance to architectural state is 2 edges.
- x0 writes:
  - The request is accepted normally: ready asserted and ptr advanced.
  - write_enable_o stays 0 for that cycle.
- Throughput: one write per cycle maximum; no internal buffering beyond the output register.
- No backpressure from the register file; the output stage never stalls.
- Flush:
  - Blocks new grants only.
  - A write already in the output register still drives write_enable_o in the following cycle.
- Same-destination requests from different sources in one cycle:
  - Only the granted one is written.
  - The others wait, so ordering follows grant order.
- Reset asserted mid-operation: output and ptr clear immediately; pending requests are lost.
- Reset deasserted: arbitration starts from ptr=0.
- busy_o = |(req_valid_i & ~req_ready_o).

Test Plan:
- Reset with all three sources valid, then release: cycle 1 grants src0 (ready=3'b001). Next cycle, write_enable_o=1 with src0's addr/data and wb_src_o=0. The asynchronous clear is checked by asserting rsn_i between edges.
- All three valid continuously with addrs 5,6,7 and data A,B,C: grant sequence is 0,1,2,0. write_enable_o is high every cycle from the 2nd cycle, addr sequence 5,6,7,5.
- Only src2 valid, then src1 and src2 valid: src2 granted (ptr→0), then src1 granted. Checks the wrap-around scan.
- src1 requests addr 0 with data 0xDEADBEEF: ready[1]=1, ptr→2, write_enable_o=0 next cycle, busy_o=0.
- flush_i=1 for two cycles with src0 valid: req_ready_o=0 and busy_o=1. A write granted the cycle before the flush still appears on write_enable_o. src0 is granted after flush drops.
- src0 and src1 both target addr 10 with data 1 and 2, ptr=0: output shows 1 then 2; the register file ends holding 2.

Source files
------------

// File: rtl/int_wb_arbiter.sv
// int_wb_arbiter: round-robin share of the int register file write port; in: clk_i, rsn_i, flush_i, req_valid_i/addr_i/data_i; out: req_ready_o (comb one-hot grant), registered write_enable_o/addr_o/data_o, wb_src_o, busy_o
module int_wb_arbiter #(
  parameter int N_SRC = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk_i,
  input  logic                     rsn_i,
  input  logic                     flush_i,
  input  logic [N_SRC-1:0]         req_valid_i,
  input  logic [N_SRC*ADDR_W-1:0]  req_addr_i,
  input  logic [N_SRC*DATA_W-1:0]  req_data_i,
  output logic [N_SRC-1:0]         req_ready_o,
  output logic                     write_enable_o,
  output logic [ADDR_W-1:0]        write_addr_o,
  output logic [DATA_W-1:0]        write_data_o,
  output logic [2:0]               wb_src_o,
  output logic                     busy_o
);
  localparam int PW = $clog2(N_SRC);
  logic [PW-1:0] ptr, gnt_idx, idx;
  logic found, xfer;
  int sum;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  always_comb begin
    found = 1'b0;
    gnt_idx = '0;
    idx = '0;
    sum = 0;
    for (int k = 0; k < N_SRC; k++) begin
      sum = int'(ptr) + k;
      idx = PW'(sum >= N_SRC ? sum - N_SRC : sum);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        gnt_idx = idx;
      end
    end
  end
  assign xfer = found && rsn_i && !flush_i;
  assign req_ready_o = xfer ? N_SRC'(1) << gnt_idx : '0;
  assign busy_o = |(req_valid_i & ~req_ready_o);
  assign g_addr = req_addr_i[gnt_idx*ADDR_W +: ADDR_W];
  assign g_data = req_data_i[gnt_idx*DATA_W +: DATA_W];
  always_ff @(posedge clk_i or negedge rsn_i)
    if (!rsn_i) begin
      ptr <= '0;
      write_enable_o <= 1'b0;
      write_addr_o <= '0;
      write_data_o <= '0;
      wb_src_o <= '0;
    end else begin
      write_enable_o <= xfer && |g_addr;
      if (xfer) begin
        ptr <= (int'(gnt_idx) == N_SRC - 1) ? '0 : gnt_idx + 1'b1;
        write_addr_o <= g_addr;
        write_data_o <= g_data;
        wb_src_o <= 3'(gnt_idx);
      end
    end
endmodule
